// File: rtl/im_fetch_responder.sv
// Instruction-memory responder for the IF->IM fetch interface: boot ROM and text
// regions, fixed wait-state latency, stall to IF, and a backdoor preload port.
module im_fetch_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BOOT_BASE   = 32'hBFC00000,
  parameter logic [31:0] TEXT_BASE   = 32'h00400000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] InstructionAddress_IN,
  input  logic        FetchRequest_IN,
  input  logic        Flush_IN,
  input  logic        LoadEnable_IN,
  input  logic [31:0] LoadAddress_IN,
  input  logic [31:0] LoadData_IN,
  output logic [31:0] Instruction_OUT,
  output logic        InstructionValid_OUT,
  output logic        FetchError_OUT,
  output logic        STALL_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                 err;
    logic                 boot;
    logic [ADDR_BITS-1:0] idx;
  } dec_t;

  localparam logic [32:0] SPAN = 33'd4 << ADDR_BITS;

  // Window test on full-width offsets so addresses past a region never alias into it.
  function automatic dec_t decode(input logic [31:0] a);
    dec_t        d;
    logic [32:0] bo;
    logic [32:0] to;
    bo     = {1'b0, a} - {1'b0, BOOT_BASE};
    to     = {1'b0, a} - {1'b0, TEXT_BASE};
    d.err  = 1'b0;
    d.boot = 1'b0;
    d.idx  = '0;
    if (a[1:0] != 2'b00) begin
      d.err = 1'b1;
    end else if ((a >= BOOT_BASE) && (bo < SPAN)) begin
      d.boot = 1'b1;
      d.idx  = ADDR_BITS'(bo >> 2);
    end else if ((a >= TEXT_BASE) && (to < SPAN)) begin
      d.idx  = ADDR_BITS'(to >> 2);
    end else begin
      d.err = 1'b1;
    end
    return d;
  endfunction

  logic [31:0] boot_mem [2**ADDR_BITS];
  logic [31:0] text_mem [2**ADDR_BITS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic [31:0] fetch_addr;
  dec_t        fdec;
  dec_t        ldec;
  logic        ld_we;
  logic        bypass;
  logic [31:0] rd_word;
  logic        accept;
  logic        enter_resp;

  // With zero wait states RESP is entered on the accept edge, so decode the live address.
  assign fetch_addr = (state_q == S_IDLE) ? InstructionAddress_IN : addr_q;
  assign fdec       = decode(fetch_addr);
  assign ldec       = decode(LoadAddress_IN);
  assign ld_we      = LoadEnable_IN && (state_q == S_IDLE) && !ldec.err;
  assign bypass     = ld_we && (ldec.boot == fdec.boot) && (ldec.idx == fdec.idx);
  assign rd_word    = bypass    ? LoadData_IN :
                      fdec.boot ? boot_mem[fdec.idx] : text_mem[fdec.idx];
  assign accept     = (state_q == S_IDLE) && FetchRequest_IN && !Flush_IN;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = InstructionAddress_IN;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (Flush_IN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      instr_d = fdec.err ? '0 : rd_word;
      err_d   = fdec.err;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (ld_we) begin
      if (ldec.boot) boot_mem[ldec.idx] <= LoadData_IN;
      else           text_mem[ldec.idx] <= LoadData_IN;
    end
  end

  assign Instruction_OUT      = instr_q;
  assign InstructionValid_OUT = (state_q == S_RESP) && !Flush_IN;
  assign FetchError_OUT       = (state_q == S_RESP) && err_q && !Flush_IN;
  assign STALL_OUT            = (state_q == S_WAIT) ||
                                ((state_q == S_IDLE) && FetchRequest_IN && !Flush_IN);

endmodule

// File: tb/tb_im_fetch_responder.sv
// Bench for im_fetch_responder: two instances (2 and 0 wait states) checked against
// a word-addressed memory model and the documented fetch latency.
module tb_im_fetch_responder;

  localparam int unsigned AB   = 10;
  localparam longint      BOOT = 64'h00000000BFC00000;
  localparam longint      TEXT = 64'h0000000000400000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req [2];
  logic        fl  [2];
  logic        le  [2];
  logic [31:0] ia  [2];
  logic [31:0] la  [2];
  logic [31:0] ld  [2];
  logic [31:0] ins [2];
  logic        vld [2];
  logic        er  [2];
  logic        stl [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [longint];

  im_fetch_responder #(.ADDR_BITS(AB), .WAIT_STATES(2)) u_ws2 (
    .CLOCK(clk), .RESET(rst),
    .InstructionAddress_IN(ia[0]), .FetchRequest_IN(req[0]), .Flush_IN(fl[0]),
    .LoadEnable_IN(le[0]), .LoadAddress_IN(la[0]), .LoadData_IN(ld[0]),
    .Instruction_OUT(ins[0]), .InstructionValid_OUT(vld[0]),
    .FetchError_OUT(er[0]), .STALL_OUT(stl[0])
  );

  im_fetch_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_ws0 (
    .CLOCK(clk), .RESET(rst),
    .InstructionAddress_IN(ia[1]), .FetchRequest_IN(req[1]), .Flush_IN(fl[1]),
    .LoadEnable_IN(le[1]), .LoadAddress_IN(la[1]), .LoadData_IN(ld[1]),
    .Instruction_OUT(ins[1]), .InstructionValid_OUT(vld[1]),
    .FetchError_OUT(er[1]), .STALL_OUT(stl[1])
  );

  function automatic int ws(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    longint x;
    longint span;
    x    = longint'(a);
    span = 4 * (longint'(1) << AB);
    if (x % 4 != 0) return 1'b0;
    if (x >= BOOT && x < BOOT + span) return 1'b1;
    if (x >= TEXT && x < TEXT + span) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint key(input int s, input logic [31:0] a);
    return (longint'(s) << 32) | longint'(a);
  endfunction

  function automatic logic [31:0] pool_addr(input int p);
    longint base;
    int     k;
    int     idx;
    base = (p < 10) ? BOOT : TEXT;
    k    = p % 10;
    idx  = (k < 8) ? k : 1014 + k;
    return 32'(base + 4 * idx);
  endfunction

  function automatic logic [31:0] unmapped_addr(input int j);
    case (j)
      0:       return 32'hBFBFFFFC;
      1:       return 32'hBFC01000;
      2:       return 32'h003FFFFC;
      3:       return 32'h00401000;
      4:       return 32'h00000000;
      default: return 32'hFFFFFFFC;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int s, input logic [31:0] a, input logic [31:0] d);
    le[s] = 1'b1;
    la[s] = a;
    ld[s] = d;
    if (mapped(a)) mdl[key(s, a)] = d;
    tick();
    le[s] = 1'b0;
  endtask

  task automatic fetch(input int s, input logic [31:0] a, input bit same_ld,
                       input logic [31:0] d, input bit fl_resp);
    bit          exp_e;
    logic [31:0] exp_i;
    ia[s]  = a;
    req[s] = 1'b1;
    if (same_ld) begin
      le[s] = 1'b1;
      la[s] = a;
      ld[s] = d;
      if (mapped(a)) mdl[key(s, a)] = d;
    end
    exp_e = !mapped(a);
    exp_i = 32'h0;
    if (!exp_e && mdl.exists(key(s, a))) exp_i = mdl[key(s, a)];
    #1 chk("stall_req", 32'(stl[s]), 32'd1);
    tick();
    req[s] = 1'b0;
    le[s]  = 1'b0;
    for (int i = 1; i <= ws(s); i++) begin
      chk("stall_wait", 32'(stl[s]), 32'd1);
      chk("valid_wait", 32'(vld[s]), 32'd0);
      tick();
    end
    fl[s] = fl_resp;
    #1;
    chk("valid_resp", 32'(vld[s]), 32'(!fl_resp));
    chk("error_resp", 32'(er[s]), 32'(exp_e && !fl_resp));
    chk("instr_resp", ins[s], exp_i);
    chk("stall_resp", 32'(stl[s]), 32'd0);
    tick();
    fl[s] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; fl[s] = 1'b0; le[s] = 1'b0;
      ia[s] = '0; la[s] = '0; ld[s] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_instr", ins[s], 32'h0);
      chk("rst_valid", 32'(vld[s]), 32'd0);
      chk("rst_error", 32'(er[s]), 32'd0);
      chk("rst_stall", 32'(stl[s]), 32'd0);
    end

    // Boot word, misaligned, text window edges
    do_load(0, 32'hBFC00000, 32'h3C1DBFC0);
    fetch(0, 32'hBFC00000, 0, 0, 0);
    fetch(0, 32'hBFC00002, 0, 0, 0);
    do_load(0, 32'h00400FFC, 32'h8FBF0010);
    fetch(0, 32'h00401000, 0, 0, 0);
    fetch(0, 32'h00400FFC, 0, 0, 0);

    // Load past the boot window must not alias onto boot[0]
    do_load(0, 32'hBFC01000, 32'hDEADBEEF);
    fetch(0, 32'hBFC00000, 0, 0, 0);
    fetch(0, 32'hBFC01000, 0, 0, 0);

    // Flush in the first wait cycle
    ia[0] = 32'hBFC00000;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    fl[0] = 1'b1;
    #1 chk("flush_wait_stall", 32'(stl[0]), 32'd1);
    tick();
    fl[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", 32'(vld[0]), 32'd0);
      chk("flush_stall_low", 32'(stl[0]), 32'd0);
      tick();
    end

    // Flush together with request in IDLE: nothing captured
    ia[1] = 32'hBFC00000;
    req[1] = 1'b1;
    fl[1] = 1'b1;
    #1 chk("flush_req_stall", 32'(stl[1]), 32'd0);
    tick();
    req[1] = 1'b0;
    fl[1] = 1'b0;
    #1 chk("flush_req_no_valid", 32'(vld[1]), 32'd0);
    tick();

    // Zero wait states, back-to-back, then flush in RESP and same-cycle load
    do_load(1, 32'hBFC00000, 32'h11112222);
    do_load(1, 32'hBFC00004, 32'h33334444);
    fetch(1, 32'hBFC00000, 0, 0, 0);
    fetch(1, 32'hBFC00004, 0, 0, 0);
    fetch(1, 32'hBFC00004, 0, 0, 1);
    fetch(1, 32'hBFC00000, 1, 32'hCAFEF00D, 0);
    fetch(0, 32'h00400FFC, 1, 32'h0BADC0DE, 0);

    // Reset during WAIT
    ia[0] = 32'hBFC00000;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_instr", ins[0], 32'h0);
    chk("rstw_valid", 32'(vld[0]), 32'd0);
    chk("rstw_error", 32'(er[0]), 32'd0);
    chk("rstw_stall", 32'(stl[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstw_no_valid", 32'(vld[0]), 32'd0);
      tick();
    end
    fetch(0, 32'hBFC00000, 0, 0, 0);

    // Randomised traffic over a pool of preloaded words
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 20; p++)
        do_load(s, pool_addr(p), $urandom);
    for (int it = 0; it < 80; it++) begin
      int          s;
      int          kind;
      logic [31:0] a;
      s    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      a    = pool_addr($urandom_range(0, 19));
      if (kind < 3)
        do_load(s, a, $urandom);
      else if (kind < 7)
        fetch(s, a, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 4) == 0);
      else if (kind == 7)
        fetch(s, a | 32'($urandom_range(1, 3)), 0, 0, 0);
      else if (kind == 8)
        fetch(s, unmapped_addr($urandom_range(0, 5)), 0, 0, 0);
      else
        fetch(s, {4'h2, 26'($urandom), 2'b00}, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/im_fetch_responder.md
Name: im_fetch_responder

Overview:
- Instruction-memory responder: the memory end of the IF→IM address interface.
- Accepts the fetch address that IF drives from its program counter and decodes it into the boot ROM region or the text region.
- Returns the instruction word after a configurable number of wait states and holds IF with a stall signal while the fetch is outstanding.
- Includes a backdoor load port so benches and the boot loader can preload program images.

Parameters:
- ADDR_BITS, 10, log2 of words per region (each region holds 2^ADDR_BITS words).
- WAIT_STATES, 2, extra memory cycles per fetch; legal range 0–15.
- BOOT_BASE, 32'hBFC00000, byte base of the boot ROM region.
- TEXT_BASE, 32'h00400000, byte base of the text region.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- InstructionAddress_IN  input  32  byte fetch address from IF.
- FetchRequest_IN  input  1  IF presents a valid address this cycle.
- Flush_IN  input  1  redirect or flush from ID; abandons the outstanding fetch.
- LoadEnable_IN  input  1  backdoor write strobe.
- LoadAddress_IN  input  32  backdoor byte address.
- LoadData_IN  input  32  backdoor write data.
- Instruction_OUT  output  32  fetched instruction word (registered).
- InstructionValid_OUT  output  1  one-cycle strobe: Instruction_OUT is valid.
- FetchError_OUT  output  1  one-cycle strobe with valid: misaligned or unmapped fetch.
- STALL_OUT  output  1  to IF STALL input; IF holds its PC while this is high.

Behaviour:
- Reset values (RESET high at the edge): state IDLE, wait counter 0, captured address 0, Instruction_OUT 0, internal error flag 0.
  - Memory arrays are not cleared.
  - Reset mid-fetch abandons the fetch; no valid strobe follows.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - FetchRequest_IN=1 and Flush_IN=0: capture the address and decode result.
    - WAIT_STATES=0: go to RESP.
    - Otherwise: go to WAIT with counter=WAIT_STATES.
  - Otherwise: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - Counter=1 at the edge: go to RESP.
  - Flush_IN=1: go to IDLE, counter cleared.
- Edge entering RESP: Instruction_OUT loads the memory word, or 32'h00000000 (NOP) on error; the error flag is registered.
- RESP:
  - InstructionValid_OUT = !Flush_IN.
  - FetchError_OUT = error flag & !Flush_IN.
  - Unconditionally return to IDLE.
  - A new request is not accepted in RESP; IF re-presents it in the next IDLE cycle.
- STALL_OUT (combinational):
  - High in WAIT.
  - High in IDLE when FetchRequest_IN & !Flush_IN.
  - Low in RESP, so IF advances its PC on the edge that ends RESP.
- Latency: request in cycle 0 → valid in cycle 1+WAIT_STATES. STALL_OUT is high for WAIT_STATES+1 cycles.
- Address decode, evaluated in priority order:
  1. addr[1:0]≠0 → misaligned error.
  2. BOOT_BASE ≤ addr < BOOT_BASE+4·2^ADDR_BITS → boot array, index (addr−BOOT_BASE)>>2.
  3. Same window rule at TEXT_BASE → text array.
  4. Otherwise → unmapped error.
  - Subtraction is full 32-bit unsigned with no wrap; the window check must use a ≥-and-< comparison, not index truncation.
- Errors take the same latency and response path as normal fetches: Instruction_OUT = NOP.
- Backdoor load:
  - Write occurs on the edge when LoadEnable_IN=1 and state=IDLE.
  - Ignored in WAIT/RESP.
  - Ignored when the load address decodes to an error.
  - A load in the same IDLE cycle as an accepted fetch to the same word is visible to that fetch (array read happens at RESP entry).
- Boundary cases:
  - Flush_IN and FetchRequest_IN together in IDLE: no capture, STALL_OUT low.
  - Flush_IN in RESP: strobe suppressed, Instruction_OUT still updates.
  - Last word of a region (base+4·(2^ADDR_BITS−1)) is mapped; the next word is unmapped.

Test Plan:
- Reset, preload boot[0]=32'h3C1DBFC0, request 32'hBFC00000 with WAIT_STATES=2 → STALL_OUT high cycles 0–2; valid in cycle 3 with Instruction_OUT=32'h3C1DBFC0, FetchError_OUT=0.
- Request 32'hBFC00002 → after the same latency, valid=1, FetchError_OUT=1, Instruction_OUT=0.
- Request 32'h00401000 (ADDR_BITS=10, first word past the text window) → error strobe; request 32'h00400FFC → mapped word returned, no error.
- Request accepted, Flush_IN pulsed in cycle 1 → back to IDLE, no valid strobe, STALL_OUT low in cycle 2.
- WAIT_STATES=0, back-to-back requests to 0xBFC00000 and 0xBFC00004 → valids in cycles 1 and 3, STALL_OUT pattern 1,0,1,0.
- RESET asserted in a WAIT cycle → next cycle IDLE, all outputs 0, preloaded memory contents intact on a refetch.
